// File: rtl/alu_share_pkg.sv
// Shared definitions for the ALU sharing arbiter.
// Holds the ALU op width and the RV32I-style op encodings used by the
// requesters and by the stage-2 compute in alu_share_arbiter.
package alu_share_pkg;

    localparam int unsigned OP_W = 4;

    localparam logic [OP_W-1:0] OP_ADD = 4'b0000;
    localparam logic [OP_W-1:0] OP_SUB = 4'b0001;
    localparam logic [OP_W-1:0] OP_AND = 4'b0010;
    localparam logic [OP_W-1:0] OP_OR  = 4'b0011;
    localparam logic [OP_W-1:0] OP_XOR = 4'b0100;
    localparam logic [OP_W-1:0] OP_SLL = 4'b0101;
    localparam logic [OP_W-1:0] OP_SRL = 4'b0110;
    localparam logic [OP_W-1:0] OP_SRA = 4'b0111;
    localparam logic [OP_W-1:0] OP_SLT = 4'b1000;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter.
// The search for a winner starts one past the last granted index, so the
// most recently served requester has lowest priority. The pointer resets to
// N-1, giving requester 0 first priority, and moves only when advance is high.
// Ports:
//   clk       clock, rising edge
//   rst_n     asynchronous active-low reset
//   req       request vector
//   advance   high only when the current grant is actually accepted
//   grant     one-hot grant (zero when no request)
//   grant_idx binary index of the granted requester
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    input  logic                 advance,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx
);

    localparam int unsigned PW = $clog2(N);
    localparam logic [PW-1:0] PtrInit = PW'(N - 1);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] cand;
    logic          found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        cand      = '0;
        found     = 1'b0;
        for (int unsigned off = 1; off <= N; off++) begin
            cand = PW'((32'(ptr_q) + off) % N);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= PtrInit;
        end else if (advance) begin
            ptr_q <= grant_idx;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU datapath among NUM_REQ requesters.
// A round-robin arbiter picks one request per cycle; the winner passes through
// stage 1 (operand capture) and stage 2 (ALU compute into the result register),
// then is presented on a valid/ready response channel tagged with its ID.
// A stalled response (s2 valid, consumer not ready) freezes the whole pipe.
// Ports:
//   clk, rst_n             clock and asynchronous active-low reset
//   req_valid / req_ready  per-requester handshake (req_ready one-hot or zero)
//   req_op, req_a, req_b   per-requester op and operands, slice i = requester i
//   rsp_valid / rsp_ready  response handshake
//   rsp_id, rsp_data       requester index and ALU result
//   busy                   any pipeline stage occupied
// Optional feature, macro ALU_SHARE_ARB_PERF_EN: adds grant_cnt (saturating
// per-requester handshake counts) and stall_cnt (saturating stall cycles).
module alu_share_arbiter
    import alu_share_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2,
    parameter int unsigned XLEN    = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [OP_W*NUM_REQ-1:0] req_op,
    input  logic [XLEN*NUM_REQ-1:0] req_a,
    input  logic [XLEN*NUM_REQ-1:0] req_b,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [XLEN-1:0]         rsp_data,
    output logic                    busy
`ifdef ALU_SHARE_ARB_PERF_EN
    ,
    output logic [32*NUM_REQ-1:0]   grant_cnt,
    output logic [31:0]             stall_cnt
`endif
);

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               stall;
    logic               hs;

    logic               s1_valid_q;
    logic [OP_W-1:0]    s1_op_q;
    logic [XLEN-1:0]    s1_a_q;
    logic [XLEN-1:0]    s1_b_q;
    logic [ID_W-1:0]    s1_id_q;

    logic               s2_valid_q;
    logic [ID_W-1:0]    s2_id_q;
    logic [XLEN-1:0]    s2_data_q;

    logic [XLEN-1:0]    alu_result;
    logic [4:0]         shamt;

    assign stall     = s2_valid_q & ~rsp_ready;
    assign req_ready = grant & {NUM_REQ{~stall}};
    assign hs        = |(req_valid & req_ready);

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr_arbiter (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req_valid),
        .advance   (hs),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Stage 1: operand capture from the granted slice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= '0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_id_q    <= '0;
        end else if (!stall) begin
            s1_valid_q <= hs;
            if (hs) begin
                s1_op_q <= req_op[grant_idx*OP_W +: OP_W];
                s1_a_q  <= req_a[grant_idx*XLEN +: XLEN];
                s1_b_q  <= req_b[grant_idx*XLEN +: XLEN];
                s1_id_q <= grant_idx;
            end
        end
    end

    // Stage 2 ALU compute; undefined op codes produce zero.
    assign shamt = s1_b_q[4:0];

    always_comb begin
        alu_result = '0;
        case (s1_op_q)
            OP_ADD:  alu_result = s1_a_q + s1_b_q;
            OP_SUB:  alu_result = s1_a_q - s1_b_q;
            OP_AND:  alu_result = s1_a_q & s1_b_q;
            OP_OR:   alu_result = s1_a_q | s1_b_q;
            OP_XOR:  alu_result = s1_a_q ^ s1_b_q;
            OP_SLL:  alu_result = s1_a_q << shamt;
            OP_SRL:  alu_result = s1_a_q >> shamt;
            OP_SRA:  alu_result = XLEN'($signed(s1_a_q) >>> shamt);
            OP_SLT:  alu_result = {{(XLEN-1){1'b0}}, $signed(s1_a_q) < $signed(s1_b_q)};
            default: alu_result = '0;
        endcase
    end

    // Result register keeps its last value while no new result arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_id_q    <= '0;
            s2_data_q  <= '0;
        end else if (!stall) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_id_q   <= s1_id_q;
                s2_data_q <= alu_result;
            end
        end
    end

    assign rsp_valid = s2_valid_q;
    assign rsp_id    = s2_id_q;
    assign rsp_data  = s2_data_q;
    assign busy      = s1_valid_q | s2_valid_q;

`ifdef ALU_SHARE_ARB_PERF_EN
    logic [31:0] stall_cnt_q;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_grant_cnt
        logic [31:0] cnt_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
            end else if (req_valid[i] && req_ready[i] && (cnt_q != '1)) begin
                cnt_q <= cnt_q + 32'd1;
            end
        end
        assign grant_cnt[i*32 +: 32] = cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;
    import alu_share_pkg::*;

    localparam int NR = 4;

    logic          clk;
    logic          rst_n;
    logic [NR-1:0] req_valid;
    logic [NR-1:0] req_ready;
    logic [4*NR-1:0]  req_op;
    logic [32*NR-1:0] req_a;
    logic [32*NR-1:0] req_b;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [1:0]    rsp_id;
    logic [31:0]   rsp_data;
    logic          busy;
`ifdef ALU_SHARE_ARB_PERF_EN
    logic [32*NR-1:0] grant_cnt;
    logic [31:0]      stall_cnt;
`endif

    alu_share_arbiter #(
        .NUM_REQ (NR),
        .ID_W    (2),
        .XLEN    (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .busy      (busy)
`ifdef ALU_SHARE_ARB_PERF_EN
        ,
        .grant_cnt (grant_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          rid;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [1:0]  id;
        logic [31:0] data;
    } sb_t;

    vec_t vecs[12];
    sb_t  sbq[$];
    bit   sb_en;
    int   tests;
    int   failed;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One clock cycle; with the scoreboard enabled, record handshakes and
    // check completions against grant order.
    task automatic step();
        sb_t e;
        #1;
        if (sb_en) begin
            if (rsp_valid && rsp_ready) begin
                tests++;
                if (sbq.size() == 0) begin
                    failed++;
                    $display("FAIL sb_unexpected: got id %0d data %h, expected none", rsp_id,
                             rsp_data);
                end else begin
                    e = sbq.pop_front();
                    tests--;
                    chk("sb_rsp_id", 32'(rsp_id), 32'(e.id));
                    chk("sb_rsp_data", rsp_data, e.data);
                end
            end
            for (int i = 0; i < NR; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    e.id   = 2'(i);
                    e.data = req_a[i*32 +: 32] + req_b[i*32 +: 32];
                    sbq.push_back(e);
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic stream_ops();
        for (int i = 0; i < NR; i++) begin
            req_op[i*4 +: 4] = OP_ADD;
            req_a[i*32 +: 32] = 32'h100 * (i + 1);
            req_b[i*32 +: 32] = 32'(i);
        end
    endtask

    logic [31:0] held_data;
    logic [1:0]  held_id;
    int          k;
    int          budget;
    logic [3:0]  onehot;

    initial begin
        tests = 0;
        failed = 0;
        sb_en = 1'b0;
        rst_n = 1'b0;
        req_valid = '0;
        req_op = '0;
        req_a = '0;
        req_b = '0;
        rsp_ready = 1'b1;

        vecs[0]  = '{2, OP_ADD, 32'hFFFF_FFFF, 32'h1,         32'h0};
        vecs[1]  = '{0, OP_SUB, 32'h0,         32'h1,         32'hFFFF_FFFF};
        vecs[2]  = '{1, OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000};
        vecs[3]  = '{3, OP_OR,  32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0};
        vecs[4]  = '{0, OP_XOR, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555};
        vecs[5]  = '{1, OP_SLL, 32'h1,         32'h24,        32'h10};
        vecs[6]  = '{2, OP_SRL, 32'h8000_0000, 32'h1F,        32'h1};
        vecs[7]  = '{3, OP_SRA, 32'h8000_0000, 32'h21,        32'hC000_0000};
        vecs[8]  = '{0, OP_SLT, 32'hFFFF_FFFF, 32'h1,         32'h1};
        vecs[9]  = '{1, OP_SLT, 32'h1,         32'hFFFF_FFFF, 32'h0};
        vecs[10] = '{2, 4'hF,   32'h123,       32'h456,       32'h0};
        vecs[11] = '{3, 4'h9,   32'h5,         32'h5,         32'h0};

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_rsp_id", 32'(rsp_id), 32'h0);
        chk("rst_rsp_data", rsp_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Continuous streaming with round-robin order, then backpressure.
        sb_en = 1'b1;
        stream_ops();
        req_valid = '1;
        k = 0;
        for (int c = 0; c < 8; c++) begin
            #1;
            onehot = 4'b0001 << (k % NR);
            chk($sformatf("rr_grant%0d", k), 32'(req_ready), 32'(onehot));
            k++;
            step();
        end
        rsp_ready = 1'b0;
        #1;
        held_data = rsp_data;
        held_id = rsp_id;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("bp_req_ready%0d", c), 32'(req_ready), 32'h0);
            chk($sformatf("bp_rsp_valid%0d", c), 32'(rsp_valid), 32'h1);
            chk($sformatf("bp_rsp_data%0d", c), rsp_data, held_data);
            chk($sformatf("bp_rsp_id%0d", c), 32'(rsp_id), 32'(held_id));
            step();
        end
        rsp_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            onehot = 4'b0001 << (k % NR);
            chk($sformatf("rr_grant%0d", k), 32'(req_ready), 32'(onehot));
            k++;
            step();
        end
        req_valid = '0;
        budget = 10;
        while (busy && budget > 0) begin
            step();
            budget--;
        end
        step();
        chk("drain_busy", 32'(busy), 32'h0);
        chk("drain_sb_left", 32'(sbq.size()), 32'h0);
        sb_en = 1'b0;

        // Table-driven single-request vectors.
        for (int i = 0; i < 12; i++) begin
            req_op = '0;
            req_a = '0;
            req_b = '0;
            req_op[vecs[i].rid*4 +: 4] = vecs[i].op;
            req_a[vecs[i].rid*32 +: 32] = vecs[i].a;
            req_b[vecs[i].rid*32 +: 32] = vecs[i].b;
            req_valid = 4'(1 << vecs[i].rid);
            #1;
            chk($sformatf("vec%0d_ready", i), 32'(req_ready), 32'(1 << vecs[i].rid));
            step();
            req_valid = '0;
            #1;
            chk($sformatf("vec%0d_early", i), 32'(rsp_valid), 32'h0);
            step();
            chk($sformatf("vec%0d_valid", i), 32'(rsp_valid), 32'h1);
            chk($sformatf("vec%0d_id", i), 32'(rsp_id), 32'(vecs[i].rid));
            chk($sformatf("vec%0d_data", i), rsp_data, vecs[i].exp);
            step();
            chk($sformatf("vec%0d_done", i), 32'(rsp_valid), 32'h0);
        end

        // Reset with both stages occupied; requester 0 wins first afterwards.
        stream_ops();
        req_valid = '1;
        step();
        step();
        step();
        #1;
        chk("mid_busy_before", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("mid_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("mid_busy", 32'(busy), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mid_first_grant", 32'(req_ready), 32'h1);
        step();
        step();
        chk("mid_first_rsp_id", 32'(rsp_id), 32'h0);
        req_valid = '0;
        repeat (4) step();
        chk("mid_drain_busy", 32'(busy), 32'h0);

`ifdef ALU_SHARE_ARB_PERF_EN
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("perf_rst_grant1", grant_cnt[63:32], 32'h0);
        chk("perf_rst_stall", stall_cnt, 32'h0);
        req_valid = 4'b0010;
        repeat (3) step();
        req_valid = '0;
        rsp_ready = 1'b0;
        repeat (4) step();
        rsp_ready = 1'b1;
        repeat (4) step();
        chk("perf_grant1", grant_cnt[63:32], 32'h3);
        chk("perf_grant0", grant_cnt[31:0], 32'h0);
        chk("perf_stall", stall_cnt, 32'h4);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish before time limit");
        $fatal(1, "timeout");
    end

endmodule
